pair_triple_stim_checker: RTL and testbench

- Driving and checking end of the 3-input pair/triple detector interface.
- Sequences 3-bit stimulus vectors onto a detector's in0/in1/in2 and samples the detector's single-bit out after a fixed latency.
- Compares each sample against the golden rule: out = 1 iff at least two inputs are 1. Counts vectors and mismatches.
- Sits beside the detector in lab harnesses and FPGA self-test tops.

---
 rtl/pair_triple_stim_checker_pkg.sv | 33 +++
 rtl/pair_triple_stim_checker_pattern_sel.sv | 40 ++++
 rtl/pair_triple_stim_checker.sv | 168 ++++++++++++++++
 tb/tb_pair_triple_stim_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_triple_stim_checker_pkg.sv
// ============================================================================
// pair_triple_stim_checker_pkg : shared state/mode encodings and set membership
// Rev 1.0
// ============================================================================
`default_nettype none

package pair_triple_stim_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ALL     = 2'b00;
  localparam logic [1:0] MODE_PAIR    = 2'b01;
  localparam logic [1:0] MODE_NONPAIR = 2'b10;

  // Membership of a 3-bit vector in the pattern set chosen by mode (11 acts as ALL).
  function automatic logic in_set(input logic [2:0] v, input logic [1:0] mode);
    logic two_plus;
    two_plus = (v[0] & v[1]) | (v[2] & (v[0] | v[1]));
    case (mode)
      MODE_PAIR:    in_set = two_plus;
      MODE_NONPAIR: in_set = ~two_plus;
      default:      in_set = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pair_triple_stim_checker_pattern_sel.sv
// ============================================================================
// pair_triple_pattern_sel : combinational next/first matching index for a mode
// Rev 1.0
// ============================================================================
`default_nettype none

module pair_triple_pattern_sel
  import pair_triple_stim_checker_pkg::*;
(
  input  logic [2:0] idx_i,
  input  logic [1:0] mode_i,
  output logic [2:0] next_idx_o,
  output logic       wrap_o,
  output logic [2:0] first_idx_o
);

  // Scans run downward so the lowest qualifying index is the one left standing.
  always_comb begin
    first_idx_o = 3'd0;
    next_idx_o  = 3'd0;
    wrap_o      = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (in_set(3'(i), mode_i)) begin
        first_idx_o = 3'(i);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if ((3'(i) > idx_i) && in_set(3'(i), mode_i)) begin
        next_idx_o = 3'(i);
        wrap_o     = 1'b0;
      end
    end
    if (wrap_o) begin
      next_idx_o = first_idx_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pair_triple_stim_checker.sv
// ============================================================================
// pair_triple_stim_checker : drives 3-bit stimulus into a pair/triple detector
// and checks its response against the 2-of-3 rule.
// Optional: PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN adds first-failure capture.
// Rev 1.0
// ============================================================================
`default_nettype none

module pair_triple_stim_checker
  import pair_triple_stim_checker_pkg::*;
#(
  parameter int unsigned NUM_PASSES = 1,
  parameter int unsigned RESP_LAT   = 0,
  parameter int unsigned ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  output logic [2:0]       stim_o,
  output logic             stim_val_o,
  input  logic             det_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       vec_cnt_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             pass_ok_o
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
  ,
  output logic [2:0]       first_fail_o,
  output logic             first_fail_val_o
`endif
);

  localparam logic [3:0] NUM_PASSES_4 = 4'(NUM_PASSES);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [2:0]       stim_q;
  logic             stim_val_q, busy_q, done_q, pass_ok_q;
  logic [7:0]       vec_cnt_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [3:0]       pass_q;
  logic [1:0]       wait_q;

  logic [1:0]       sel_mode;
  logic [2:0]       next_idx, first_idx;
  logic             wrap;
  logic             expected, mismatch, sample, run_end;
  logic [ERR_W-1:0] err_cnt_d;

  // In IDLE the live mode input picks the first vector; afterwards the latched copy rules.
  assign sel_mode = (state_q == IDLE) ? mode_i : mode_q;

  pair_triple_pattern_sel u_sel (
    .idx_i       (stim_q),
    .mode_i      (sel_mode),
    .next_idx_o  (next_idx),
    .wrap_o      (wrap),
    .first_idx_o (first_idx)
  );

  assign expected  = (stim_q[0] & stim_q[1]) | (stim_q[2] & (stim_q[0] | stim_q[1]));
  assign mismatch  = (det_out_i != expected);
  assign sample    = ((state_q == DRIVE) && (RESP_LAT == 0)) ||
                     ((state_q == WAIT) && (wait_q == 2'd0));
  assign err_cnt_d = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  assign run_end   = wrap && ((pass_q + 4'd1) == NUM_PASSES_4);

`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
  logic [2:0] first_fail_q;
  logic       first_fail_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_q     <= 3'd0;
      first_fail_val_q <= 1'b0;
    end else if ((state_q == IDLE) && start_i) begin
      first_fail_q     <= 3'd0;
      first_fail_val_q <= 1'b0;
    end else if (sample && mismatch && !first_fail_val_q) begin
      first_fail_q     <= stim_q;
      first_fail_val_q <= 1'b1;
    end
  end

  assign first_fail_o     = first_fail_q;
  assign first_fail_val_o = first_fail_val_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ALL;
      stim_q     <= 3'd0;
      stim_val_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_ok_q  <= 1'b0;
      vec_cnt_q  <= 8'd0;
      err_cnt_q  <= '0;
      pass_q     <= 4'd0;
      wait_q     <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= DRIVE;
            mode_q     <= mode_i;
            vec_cnt_q  <= 8'd0;
            err_cnt_q  <= '0;
            pass_ok_q  <= 1'b0;
            pass_q     <= 4'd0;
            stim_q     <= first_idx;
            stim_val_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        DRIVE: begin
          if (RESP_LAT != 0) begin
            state_q <= WAIT;
            wait_q  <= 2'(RESP_LAT - 1);
          end
        end
        WAIT: begin
          if (wait_q != 2'd0) begin
            wait_q <= wait_q - 2'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Response sampling point: count the vector and step to the next one.
      if (sample) begin
        vec_cnt_q <= vec_cnt_q + 8'd1;
        err_cnt_q <= err_cnt_d;
        if (run_end) begin
          state_q    <= DONE;
          stim_q     <= 3'd0;
          stim_val_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          pass_ok_q  <= (err_cnt_d == '0);
        end else begin
          state_q <= DRIVE;
          stim_q  <= next_idx;
          pass_q  <= wrap ? pass_q + 4'd1 : pass_q;
        end
      end
    end
  end

  assign stim_o     = stim_q;
  assign stim_val_o = stim_val_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign vec_cnt_o  = vec_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign pass_ok_o  = pass_ok_q;

endmodule

`default_nettype wire

// File: tb/tb_pair_triple_stim_checker.sv
// ============================================================================
// tb_pair_triple_stim_checker : table-driven runs on three parameterisations
// plus asynchronous reset mid-run.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pair_triple_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [3];
  logic [1:0] mode  [3];
  logic       det   [3];
  logic [2:0] stim  [3];
  logic       sval  [3];
  logic       busy  [3];
  logic       done  [3];
  logic       ok    [3];
  logic [7:0] vec   [3];
  logic [3:0] err   [3];
  logic [3:0] err_a, err_c;
  logic [1:0] err_b;
  int         kind  [3];
  logic       dly1, dly2;
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
  logic [2:0] ff  [3];
  logic       ffv [3];
`endif

  int total = 0;
  int bad   = 0;

  assign err[0] = err_a;
  assign err[1] = {2'b00, err_b};
  assign err[2] = err_c;

  // Reference: count of ones, at least two.
  function automatic logic gold(input logic [2:0] v);
    return (int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2;
  endfunction

  function automatic logic model(input int k, input logic [2:0] v);
    if (k == 1) return 1'b0;
    if (k == 2) return ~gold(v);
    return gold(v);
  endfunction

  always @(posedge clk) begin
    dly1 <= gold(stim[2]);
    dly2 <= dly1;
  end

  always_comb begin
    det[0] = model(kind[0], stim[0]);
    det[1] = model(kind[1], stim[1]);
    det[2] = dly2;
  end

  pair_triple_stim_checker #(.NUM_PASSES(1), .RESP_LAT(0), .ERR_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .mode_i(mode[0]),
    .stim_o(stim[0]), .stim_val_o(sval[0]), .det_out_i(det[0]), .busy_o(busy[0]),
    .done_o(done[0]), .vec_cnt_o(vec[0]), .err_cnt_o(err_a), .pass_ok_o(ok[0])
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
    , .first_fail_o(ff[0]), .first_fail_val_o(ffv[0])
`endif
  );

  pair_triple_stim_checker #(.NUM_PASSES(2), .RESP_LAT(0), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .mode_i(mode[1]),
    .stim_o(stim[1]), .stim_val_o(sval[1]), .det_out_i(det[1]), .busy_o(busy[1]),
    .done_o(done[1]), .vec_cnt_o(vec[1]), .err_cnt_o(err_b), .pass_ok_o(ok[1])
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
    , .first_fail_o(ff[1]), .first_fail_val_o(ffv[1])
`endif
  );

  pair_triple_stim_checker #(.NUM_PASSES(1), .RESP_LAT(2), .ERR_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .mode_i(mode[2]),
    .stim_o(stim[2]), .stim_val_o(sval[2]), .det_out_i(det[2]), .busy_o(busy[2]),
    .done_o(done[2]), .vec_cnt_o(vec[2]), .err_cnt_o(err_c), .pass_ok_o(ok[2])
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
    , .first_fail_o(ff[2]), .first_fail_val_o(ffv[2])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_idx(input logic [1:0] m, input int k);
    if (m == 2'b01) begin
      case (k)
        0: return 3;
        1: return 5;
        2: return 6;
        default: return 7;
      endcase
    end else if (m == 2'b10) begin
      case (k)
        0: return 0;
        1: return 1;
        2: return 2;
        default: return 4;
      endcase
    end
    return k;
  endfunction

  typedef struct {
    int         d;
    logic [1:0] m;
    int         knd;
    int         np;
    int         lat;
    int         xvec;
    int         xerr;
    int         xok;
    int         xff;
    bit         poke;
  } row_t;

  row_t tbl[14];

  // Caller is at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic run(input int r, input row_t t);
    int n;
    n = (t.m == 2'b01 || t.m == 2'b10) ? 4 : 8;
    kind[t.d]  = t.knd;
    mode[t.d]  = t.m;
    start[t.d] = 1'b1;
    @(negedge clk);
    start[t.d] = t.poke;
    for (int p = 0; p < t.np; p++) begin
      for (int k = 0; k < n; k++) begin
        for (int c = 0; c <= t.lat; c++) begin
          chk($sformatf("row%0d stim p%0d k%0d c%0d", r, p, k, c), int'(stim[t.d]), exp_idx(t.m, k));
          chk($sformatf("row%0d stim_val k%0d", r, k), int'(sval[t.d]), 1);
          chk($sformatf("row%0d busy k%0d", r, k), int'(busy[t.d]), 1);
          chk($sformatf("row%0d done_early k%0d", r, k), int'(done[t.d]), 0);
          if (t.poke) mode[t.d] = ~t.m;
          @(negedge clk);
        end
      end
    end
    chk($sformatf("row%0d done_pulse", r), int'(done[t.d]), 1);
    chk($sformatf("row%0d done_stim", r), int'(stim[t.d]), 0);
    chk($sformatf("row%0d done_stim_val", r), int'(sval[t.d]), 0);
    chk($sformatf("row%0d done_busy", r), int'(busy[t.d]), 0);
    @(negedge clk);
    start[t.d] = 1'b0;
    mode[t.d]  = t.m;
    chk($sformatf("row%0d done_one_cycle", r), int'(done[t.d]), 0);
    chk($sformatf("row%0d idle_busy", r), int'(busy[t.d]), 0);
    chk($sformatf("row%0d vec_cnt", r), int'(vec[t.d]), t.xvec);
    chk($sformatf("row%0d err_cnt", r), int'(err[t.d]), t.xerr);
    chk($sformatf("row%0d pass_ok", r), int'(ok[t.d]), t.xok);
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
    chk($sformatf("row%0d first_fail_val", r), int'(ffv[t.d]), (t.xff >= 0) ? 1 : 0);
    if (t.xff >= 0) chk($sformatf("row%0d first_fail", r), int'(ff[t.d]), t.xff);
`endif
    @(negedge clk);
  endtask

  initial begin
    //          d  m      knd np lat vec err ok  ff  poke
    tbl[0]  = '{0, 2'b00, 0, 1, 0,  8,  0, 1, -1, 1'b0};
    tbl[1]  = '{0, 2'b11, 0, 1, 0,  8,  0, 1, -1, 1'b0};
    tbl[2]  = '{0, 2'b01, 0, 1, 0,  4,  0, 1, -1, 1'b0};
    tbl[3]  = '{0, 2'b10, 0, 1, 0,  4,  0, 1, -1, 1'b0};
    tbl[4]  = '{0, 2'b00, 1, 1, 0,  8,  4, 0,  3, 1'b0};
    tbl[5]  = '{0, 2'b01, 1, 1, 0,  4,  4, 0,  3, 1'b0};
    tbl[6]  = '{0, 2'b10, 1, 1, 0,  4,  0, 1, -1, 1'b0};
    tbl[7]  = '{0, 2'b00, 2, 1, 0,  8,  8, 0,  0, 1'b0};
    tbl[8]  = '{0, 2'b10, 2, 1, 0,  4,  4, 0,  0, 1'b1};
    tbl[9]  = '{1, 2'b01, 0, 2, 0,  8,  0, 1, -1, 1'b0};
    tbl[10] = '{1, 2'b00, 2, 2, 0, 16,  3, 0,  0, 1'b0};
    tbl[11] = '{1, 2'b01, 0, 2, 0,  8,  0, 1, -1, 1'b1};
    tbl[12] = '{2, 2'b10, 0, 1, 2,  4,  0, 1, -1, 1'b0};
    tbl[13] = '{2, 2'b00, 0, 1, 2,  8,  0, 1, -1, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      mode[d]  = 2'b00;
      kind[d]  = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d += 2) begin
      chk($sformatf("reset stim d%0d", d), int'(stim[d]), 0);
      chk($sformatf("reset stim_val d%0d", d), int'(sval[d]), 0);
      chk($sformatf("reset busy d%0d", d), int'(busy[d]), 0);
      chk($sformatf("reset done d%0d", d), int'(done[d]), 0);
      chk($sformatf("reset vec_cnt d%0d", d), int'(vec[d]), 0);
      chk($sformatf("reset err_cnt d%0d", d), int'(err[d]), 0);
      chk($sformatf("reset pass_ok d%0d", d), int'(ok[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 14; r++) run(r, tbl[r]);

    // Asynchronous reset while stimulus 4 is being driven, after one mismatch on 3.
    kind[0]  = 1;
    mode[0]  = 2'b00;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("prereset stim", int'(stim[0]), 4);
    chk("prereset vec_cnt", int'(vec[0]), 4);
    chk("prereset err_cnt", int'(err[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async stim", int'(stim[0]), 0);
    chk("async stim_val", int'(sval[0]), 0);
    chk("async busy", int'(busy[0]), 0);
    chk("async err_cnt", int'(err[0]), 0);
    chk("async vec_cnt", int'(vec[0]), 0);
`ifdef PAIR_TRIPLE_STIM_CHECKER_FAILLOG_EN
    chk("async first_fail_val", int'(ffv[0]), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post reset busy", int'(busy[0]), 0);
    chk("post reset stim_val", int'(sval[0]), 0);
    chk("post reset done", int'(done[0]), 0);
    chk("post reset vec_cnt", int'(vec[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
